// File: rtl/segment_rule_scan.sv
// segment_rule_scan: walks one small or big rule segment, one entry per cycle, and reports the first matching rule ID.
module segment_rule_scan #(
    parameter int INDEX_BIT_LEN   = 11,
    parameter int PACKET_BIT_LEN  = 104,
    parameter int SMALL_SEG_RULES = 4,
    parameter int BIG_SEG_RULES   = 16,
    parameter int RULE_ID_BIT_LEN = 12,
    parameter int RULE_BIT_LEN    = 163,
    parameter int RULE_ADDR_LEN   = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       smallorbig_segment,
    input  logic [INDEX_BIT_LEN-1:0]   seg_index,
    input  logic [PACKET_BIT_LEN-1:0]  tupleData,
    output logic                       rule_rd_en,
    output logic                       rule_rd_big,
    output logic [RULE_ADDR_LEN-1:0]   rule_rd_addr,
    input  logic [RULE_BIT_LEN-1:0]    rule_rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       match_hit,
    output logic [RULE_ID_BIT_LEN-1:0] match_rule_id,
    output logic [4:0]                 scan_count
);
    localparam int LS = $clog2(SMALL_SEG_RULES);
    localparam int LB = $clog2(BIG_SEG_RULES);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                       state_q, state_d;
    logic [PACKET_BIT_LEN-1:0]    tuple_q, tuple_d;
    logic                         big_q, big_d;
    logic [4:0]                   cnt_q, cnt_d;
    logic                         ev_q, ev_d;
    logic [RULE_ADDR_LEN-1:0]     addr_q, addr_d;
    logic                         rd_en_q, rd_en_d;
    logic                         hit_q, hit_d;
    logic [RULE_ID_BIT_LEN-1:0]   id_q, id_d;
    logic [4:0]                   sc_q, sc_d;

    logic [RULE_ADDR_LEN-1:0] idx_ext, base;
    logic [4:0]               nsel;
    logic                     ent_v, ent_m, last, stop, nxt_en;
    logic                     unused_rsvd;

    function automatic logic pfx_ok(input logic [31:0] ip, input logic [31:0] pfx, input logic [5:0] len);
        logic [5:0]  l;
        logic [31:0] m;
        l = (len > 6'd32) ? 6'd32 : len;
        m = (l == 6'd0) ? 32'd0 : (32'hFFFF_FFFF << (6'd32 - l));
        return ((ip ^ pfx) & m) == 32'd0;
    endfunction

    assign unused_rsvd = rule_rd_data[0];
    assign idx_ext = RULE_ADDR_LEN'(seg_index);
    assign base    = smallorbig_segment ? (idx_ext << LB) : (idx_ext << LS);
    assign nsel    = big_q ? 5'(BIG_SEG_RULES) : 5'(SMALL_SEG_RULES);

    // rule_rd_data holds entry cnt_q-1 whenever ev_q is set
    assign ent_v = rule_rd_data[162];
    assign ent_m = pfx_ok(tuple_q[31:0], rule_rd_data[149:118], rule_rd_data[117:112])
                && pfx_ok(tuple_q[63:32], rule_rd_data[111:80], rule_rd_data[79:74])
                && (rule_rd_data[73:58] <= tuple_q[79:64]) && (tuple_q[79:64] <= rule_rd_data[57:42])
                && (rule_rd_data[41:26] <= tuple_q[95:80]) && (tuple_q[95:80] <= rule_rd_data[25:10])
                && (rule_rd_data[1] || (rule_rd_data[9:2] == tuple_q[103:96]));
    assign last   = cnt_q == nsel;
    assign stop   = ev_q && (!ent_v || ent_m || last);
    assign nxt_en = (cnt_q + 5'd1) < nsel;

    always_comb begin
        state_d = state_q;
        tuple_d = tuple_q;
        big_d   = big_q;
        cnt_d   = cnt_q;
        ev_d    = ev_q;
        addr_d  = addr_q;
        rd_en_d = rd_en_q;
        hit_d   = hit_q;
        id_d    = id_q;
        sc_d    = sc_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = SCAN;
                tuple_d = tupleData;
                big_d   = smallorbig_segment;
                cnt_d   = 5'd0;
                ev_d    = 1'b0;
                addr_d  = base;
                rd_en_d = 1'b1;
            end
            SCAN: if (stop) begin
                state_d = RESP;
                rd_en_d = 1'b0;
                ev_d    = 1'b0;
                hit_d   = ent_v && ent_m;
                id_d    = (ent_v && ent_m) ? rule_rd_data[161:150] : '0;
                sc_d    = cnt_q;
            end else begin
                ev_d    = 1'b1;
                cnt_d   = cnt_q + 5'd1;
                rd_en_d = nxt_en;
                addr_d  = nxt_en ? addr_q + 1'b1 : addr_q;
            end
            RESP: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tuple_q <= '0;
            big_q   <= 1'b0;
            cnt_q   <= '0;
            ev_q    <= 1'b0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            hit_q   <= 1'b0;
            id_q    <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            tuple_q <= tuple_d;
            big_q   <= big_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            hit_q   <= hit_d;
            id_q    <= id_d;
            sc_q    <= sc_d;
        end
    end

    assign in_ready      = state_q == IDLE;
    assign out_valid     = state_q == RESP;
    assign rule_rd_en    = rd_en_q;
    assign rule_rd_big   = rd_en_q & big_q;
    assign rule_rd_addr  = addr_q;
    assign match_hit     = hit_q;
    assign match_rule_id = id_q;
    assign scan_count    = sc_q;
endmodule

// File: tb/tb_segment_rule_scan.sv
// tb_segment_rule_scan: directed vectors against a behavioural rule memory, expected values hand-computed.
module tb_segment_rule_scan;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         smallorbig_segment = 1'b0;
    logic [10:0]  seg_index = '0;
    logic [103:0] tupleData = '0;
    logic         rule_rd_en, rule_rd_big;
    logic [14:0]  rule_rd_addr;
    logic [162:0] rule_rd_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         match_hit;
    logic [11:0]  match_rule_id;
    logic [4:0]   scan_count;

    int total = 0;
    int bad = 0;
    int lat;
    int alog[$];
    int blog[$];
    logic [162:0] smem[int];
    logic [162:0] bmem[int];

    segment_rule_scan dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .smallorbig_segment(smallorbig_segment), .seg_index(seg_index), .tupleData(tupleData),
        .rule_rd_en(rule_rd_en), .rule_rd_big(rule_rd_big), .rule_rd_addr(rule_rd_addr),
        .rule_rd_data(rule_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .match_hit(match_hit), .match_rule_id(match_rule_id), .scan_count(scan_count)
    );

    always #5 clk = ~clk;

    function automatic logic [162:0] lookup(input logic big, input int a);
        if (big) return bmem.exists(a) ? bmem[a] : 163'd0;
        return smem.exists(a) ? smem[a] : 163'd0;
    endfunction

    always @(posedge clk) begin
        if (rule_rd_en) begin
            alog.push_back(int'(rule_rd_addr));
            blog.push_back(int'(rule_rd_big));
            rule_rd_data <= lookup(rule_rd_big, int'(rule_rd_addr));
        end
    end

    function automatic logic [162:0] mk(input logic v, input logic [11:0] id,
        input logic [31:0] sp, input logic [5:0] sl, input logic [31:0] dp, input logic [5:0] dl,
        input logic [15:0] splo, input logic [15:0] sphi, input logic [15:0] dplo, input logic [15:0] dphi,
        input logic [7:0] pr, input logic pany);
        return {v, id, sp, sl, dp, dl, splo, sphi, dplo, dphi, pr, pany, 1'b0};
    endfunction

    function automatic logic [162:0] wild(input logic v, input logic [11:0] id);
        return mk(v, id, 32'd0, 6'd0, 32'd0, 6'd0, 16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 8'd0, 1'b1);
    endfunction

    function automatic logic [162:0] proto_miss(input logic [11:0] id);
        return mk(1'b1, id, 32'd0, 6'd0, 32'd0, 6'd0, 16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 8'd99, 1'b0);
    endfunction

    function automatic logic [103:0] tup(input logic [31:0] sip, input logic [31:0] dip,
        input logic [15:0] spt, input logic [15:0] dpt, input logic [7:0] pr);
        return {pr, dpt, spt, dip, sip};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic big, input logic [10:0] idx, input logic [103:0] t, output int l);
        @(negedge clk);
        alog.delete();
        blog.delete();
        in_valid = 1'b1;
        smallorbig_segment = big;
        seg_index = idx;
        tupleData = t;
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = 0;
        while (!out_valid && l < 40) begin
            @(posedge clk);
            #1 l++;
        end
    endtask

    task automatic release_resp();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("rel_ovalid", 32'(out_valid), 32'd0);
        check("rel_iready", 32'(in_ready), 32'd1);
    endtask

    localparam logic [31:0] IP_A = 32'h0A01_0203;
    localparam logic [31:0] IP_B = 32'hC0A8_0001;
    localparam logic [31:0] NET  = 32'h0A01_0200;

    initial begin
        smem[12] = mk(1'b1, 12'h005, IP_A, 6'd32, IP_B, 6'd32, 16'd80, 16'd80, 16'd443, 16'd443, 8'd6, 1'b0);
        for (int i = 0; i < 7; i++) bmem[32 + i] = proto_miss(12'(i + 1));
        bmem[39] = wild(1'b1, 12'h040);
        bmem[40] = wild(1'b1, 12'h041);
        smem[20] = proto_miss(12'h007);
        smem[21] = wild(1'b0, 12'h008);
        smem[22] = wild(1'b1, 12'h009);
        smem[24] = mk(1'b1, 12'h011, 32'd0, 6'd0, 32'd0, 6'd0, 16'd80, 16'd80, 16'd0, 16'hFFFF, 8'd0, 1'b1);
        smem[28] = mk(1'b1, 12'h021, NET, 6'd24, 32'd0, 6'd0, 16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 8'd0, 1'b1);
        smem[32] = mk(1'b1, 12'h022, NET, 6'd33, 32'd0, 6'd0, 16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 8'd0, 1'b1);
        for (int i = 0; i < 16; i++) bmem[64 + i] = proto_miss(12'(i + 16'h100));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_iready", 32'(in_ready), 32'd1);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_rden", 32'(rule_rd_en), 32'd0);
        check("rst_rdbig", 32'(rule_rd_big), 32'd0);
        check("rst_addr", 32'(rule_rd_addr), 32'd0);
        check("rst_hit", 32'(match_hit), 32'd0);
        check("rst_id", 32'(match_rule_id), 32'd0);
        check("rst_cnt", 32'(scan_count), 32'd0);

        run(1'b0, 11'd3, tup(IP_A, IP_B, 16'd80, 16'd443, 8'd6), lat);
        check("t1_lat", 32'(lat), 32'd2);
        check("t1_addr0", 32'(alog[0]), 32'd12);
        check("t1_hit", 32'(match_hit), 32'd1);
        check("t1_id", 32'(match_rule_id), 32'h005);
        check("t1_cnt", 32'(scan_count), 32'd1);
        check("t1_iready", 32'(in_ready), 32'd0);
        release_resp();

        run(1'b1, 11'd2, tup(IP_A, IP_B, 16'd1, 16'd2, 8'd6), lat);
        check("t2_lat", 32'(lat), 32'd9);
        for (int i = 0; i < 8; i++) check($sformatf("t2_addr%0d", i), 32'(alog[i]), 32'(32 + i));
        check("t2_big", 32'(blog[0]), 32'd1);
        check("t2_hit", 32'(match_hit), 32'd1);
        check("t2_id", 32'(match_rule_id), 32'h040);
        check("t2_cnt", 32'(scan_count), 32'd8);
        release_resp();

        run(1'b0, 11'd5, tup(IP_A, IP_B, 16'd1, 16'd2, 8'd6), lat);
        check("t3_lat", 32'(lat), 32'd3);
        check("t3_hit", 32'(match_hit), 32'd0);
        check("t3_id", 32'(match_rule_id), 32'd0);
        check("t3_cnt", 32'(scan_count), 32'd2);
        check("t3_nreads", 32'(alog.size()), 32'd3);
        check("t3_lastaddr", 32'(alog[alog.size() - 1]), 32'd22);
        check("t3_big", 32'(blog[0]), 32'd0);
        release_resp();

        run(1'b0, 11'd6, tup(IP_A, IP_B, 16'd80, 16'd2, 8'd6), lat);
        check("sp80_hit", 32'(match_hit), 32'd1);
        check("sp80_id", 32'(match_rule_id), 32'h011);
        release_resp();
        run(1'b0, 11'd6, tup(IP_A, IP_B, 16'd81, 16'd2, 8'd6), lat);
        check("sp81_hit", 32'(match_hit), 32'd0);
        check("sp81_cnt", 32'(scan_count), 32'd2);
        release_resp();

        run(1'b0, 11'd7, tup(32'h0A01_024D, IP_B, 16'd1, 16'd2, 8'd6), lat);
        check("len24_hit", 32'(match_hit), 32'd1);
        check("len24_id", 32'(match_rule_id), 32'h021);
        release_resp();
        run(1'b0, 11'd8, tup(32'h0A01_024D, IP_B, 16'd1, 16'd2, 8'd6), lat);
        check("len33_miss", 32'(match_hit), 32'd0);
        release_resp();
        run(1'b0, 11'd8, tup(NET, IP_B, 16'd1, 16'd2, 8'd6), lat);
        check("len33_hit", 32'(match_hit), 32'd1);
        check("len33_id", 32'(match_rule_id), 32'h022);
        release_resp();

        run(1'b1, 11'd4, tup(IP_A, IP_B, 16'd1, 16'd2, 8'd6), lat);
        check("t7_lat", 32'(lat), 32'd17);
        check("t7_hit", 32'(match_hit), 32'd0);
        check("t7_id", 32'(match_rule_id), 32'd0);
        check("t7_cnt", 32'(scan_count), 32'd16);
        check("t7_nreads", 32'(alog.size()), 32'd16);
        check("t7_lastaddr", 32'(alog[alog.size() - 1]), 32'd79);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_ovalid", 32'(out_valid), 32'd1);
            check("hold_iready", 32'(in_ready), 32'd0);
            check("hold_cnt", 32'(scan_count), 32'd16);
            check("hold_hit", 32'(match_hit), 32'd0);
        end
        release_resp();
        run(1'b0, 11'd3, tup(IP_A, IP_B, 16'd80, 16'd443, 8'd6), lat);
        check("t7_next_lat", 32'(lat), 32'd2);
        check("t7_next_id", 32'(match_rule_id), 32'h005);
        release_resp();

        @(negedge clk);
        in_valid = 1'b1;
        smallorbig_segment = 1'b1;
        seg_index = 11'd2;
        tupleData = tup(IP_A, IP_B, 16'd1, 16'd2, 8'd6);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ovalid", 32'(out_valid), 32'd0);
        check("mid_rst_rden", 32'(rule_rd_en), 32'd0);
        check("mid_rst_iready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        run(1'b0, 11'd3, tup(IP_A, IP_B, 16'd80, 16'd443, 8'd6), lat);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_hit", 32'(match_hit), 32'd1);
        check("post_rst_id", 32'(match_rule_id), 32'h005);
        check("post_rst_cnt", 32'(scan_count), 32'd1);
        release_resp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
